// File: rtl/enc4x2_event.sv
// Event-capturing 4-to-2 priority encoder: latches rising edges on four request lines
// and offers each event's index downstream over a valid/ready handshake.
module enc4x2_event #(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  output logic [1:0] y,
  output logic       valid,
  input  logic       ready,
  output logic [3:0] pending,
  output logic       overrun
);

  logic [3:0] a_q, a_d;
  logic [3:0] pending_q, pending_d;
  logic [1:0] y_q, y_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;

  logic [3:0] rise, served, avail;

  // Last set bit in scan order wins, so scan toward the highest-priority line.
  function automatic logic [1:0] pick(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (PRIO_HIGH) begin
      for (int i = 0; i < 4; i++) if (v[i]) idx = 2'(i);
    end else begin
      for (int i = 3; i >= 0; i--) if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  always_comb begin
    rise   = a & ~a_q;
    served = 4'b0000;
    if (valid_q && ready) served[y_q] = 1'b1;
    avail  = pending_q & ~served;

    a_d       = a;
    pending_d = avail | rise;
    overrun_d = overrun_q | (|(rise & avail));
    y_d       = y_q;
    valid_d   = valid_q;

    // Output stage sees only latched events; fresh rises arrive one edge later.
    if (!valid_q || ready) begin
      if (avail != 4'b0000) begin
        y_d     = pick(avail);
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= 4'b0000;
      pending_q <= 4'b0000;
      y_q       <= 2'b00;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      pending_q <= pending_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign y       = y_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: doc/enc4x2_event.md
# enc4x2_event

Event-capturing 4-to-2 priority encoder with a valid/ready output handshake. It is the reverse of the team's 2x4 one-hot decoders: it watches four request lines, latches each rising edge as a pending event, and emits the 2-bit index of each event to a downstream consumer, one index per handshake. It sits between raw request/interrupt lines and any block that consumes a binary code, such as a decoder or dispatcher.

## Interface
- PRIO_HIGH, default 1: 1 gives line 3 highest priority, down to line 0; 0 gives line 0 highest priority, up to line 3.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  4  request lines, level inputs, sampled on every clk edge.
- y  output  2  encoded index of the event currently offered.
- valid  output  1  y holds an event.
- ready  input  1  consumer accepts y when valid && ready at a clk edge.
- pending  output  4  events latched and not yet accepted; bit i is line i.
- overrun  output  1  sticky flag: an event arrived on a line that already had an unaccepted event.

## Operation
- Registers: a_q[3:0] (previous sample of a), pending[3:0], y[1:0], valid, overrun.
- rise = a & ~a_q. This is combinational from the current a and a_q.
- served = one-hot(y) when valid && ready, otherwise 4'b0000.
- pending_next = (pending & ~served) | rise.
- overrun is set when (rise & pending & ~served) != 0. It stays set until rst. Merged events are lost, and no second code is emitted for them.
- avail = pending & ~served.
- Output stage, evaluated when valid==0 or valid && ready:
  - If avail != 0, load y with the highest-priority set bit of avail, and set valid to 1.
  - Otherwise, set valid to 0.
- Otherwise, meaning valid && !ready, y and valid hold.
- While valid && !ready, y must not change, even when a higher-priority event arrives.
- The offered line stays set in pending until it is accepted.
- rise is not visible to the output stage in the same cycle. It reaches selection only through pending, one edge later.
- Back-to-back acceptance: with ready held at 1, a new code is presented on the edge that accepts the previous one. Throughput is 1 code per cycle.

## Timing
- Reset (asynchronous, rst=1): a_q=0, pending=0, y=2'b00, valid=0, overrun=0.
- A line already high when rst is released counts as a rise on the first edge after release.
- Reset in the middle of a transaction drops all pending and offered events without a handshake.
- Latency, with the output stage idle:
  - a goes high before edge E1.
  - At E1, pending[i] is set.
  - At E2, valid=1 and y=i.
  - This is 2 edges from the first sampling edge.
- Same-edge re-arm: if line i rises on the same edge that its offered code is accepted, pending[i] stays set. This is a new event and does not set overrun.
- A line held high generates exactly one event. It must go low for at least one sampled edge before it can generate another.
- A pulse shorter than one clock period that falls between edges is not captured. This is the required behaviour.
- The outputs pending, y, valid and overrun are registers only. There is no combinational path from ready or a to any output.

## Test plan
- Reset then single event, PRIO_HIGH=1: a=4'b0100 for 1 cycle, ready=1 -> valid=1, y=2'b10 exactly 2 edges later, for 1 cycle. pending returns to 0 and overrun=0.
- Simultaneous events, PRIO_HIGH=1: a=4'b1011 pulsed, ready=1 -> y sequence 3, 1, 0 on consecutive cycles, then valid=0. With PRIO_HIGH=0, the sequence is 0, 1, 3.
- Backpressure: event on line 0 with ready=0, then an event on line 3 3 cycles later -> y stays 0 and valid stays 1. After ready=1, y=0 is accepted, then y=3 on the next cycle.
- Overrun: pulse line 2 twice with a low cycle between, ready=0 -> overrun=1 and pending=4'b0100. After ready=1, only one y=2 is emitted. overrun stays 1 until rst.
- Same-edge re-arm: line 1 offered with ready=0. Raise ready on the same edge that line 1 has a new rise -> y=1 is accepted, then y=1 is offered again, and overrun=0.
- Asynchronous reset mid-stream: assert rst between edges while valid=1 and pending=4'b1010 -> all outputs 0 immediately, before the next edge. After release with a=4'b0001 held, valid=1 and y=0 appear 2 edges later.
